// File: rtl/lpf_meas_pkg.sv
// Shared types and helpers for the multi-channel filter-output amplitude/period meter.
package lpf_meas_pkg;

  typedef enum logic [1:0] {ACQ, LOW, HIGH} chan_state_e;

  localparam int unsigned DefDw = 12;
  localparam int unsigned DefPw = 16;

  // Operands arrive sign-extended, so the difference can never overflow for any DW below 31.
  function automatic logic signed [31:0] half_span(input logic signed [31:0] hi,
                                                   input logic signed [31:0] lo);
    return (hi - lo) >>> 1;
  endfunction

endpackage

// File: rtl/pkdet_chan.sv
// One measurement channel: hysteretic crossing FSM, extreme tracking, period counter, timeout.
module pkdet_chan
  import lpf_meas_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned PW = DefPw
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          s_valid,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] mid,
  input  logic [DW:0]   th_hi,
  input  logic [DW:0]   th_lo,
  output logic          meas_valid,
  output logic [DW-1:0] meas_amp,
  output logic [PW-1:0] meas_period,
  output logic          timeout
);

  chan_state_e state_q, state_d;

  logic [DW-1:0] vhi_q, vhi_d, vlo_q, vlo_d, amp_q, amp_d;
  logic [PW-1:0] cnt_q, cnt_d, per_q, per_d;
  logic          armed_q, armed_d, mv_q, mv_d, to_q, to_d;

  logic signed [DW:0] sample_x;
  logic               is_hi, is_lo, rise, tick, cnt_full;
  logic [PW-1:0]      cnt_inc;

  assign sample_x = $signed({sample[DW-1], sample});
  assign is_hi    = sample_x >= $signed(th_hi);
  assign is_lo    = sample_x < $signed(th_lo);
  assign rise     = (state_q == LOW) && is_hi;
  assign cnt_inc  = cnt_q + PW'(1);
  assign cnt_full = (cnt_inc == {PW{1'b1}});
  // A rising crossing restarts the count instead of advancing it.
  assign tick     = s_valid && armed_q && !rise;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACQ;
    end else if (s_valid) begin
      unique case (state_q)
        ACQ:     state_d = ($signed(sample) >= $signed(mid)) ? HIGH : LOW;
        LOW:     if (is_hi) state_d = HIGH;
        HIGH:    if (is_lo) state_d = LOW;
        default: state_d = ACQ;
      endcase
      if (tick && cnt_full) state_d = ACQ;
    end
  end

  always_comb begin
    vhi_d   = vhi_q;
    vlo_d   = vlo_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    amp_d   = amp_q;
    per_d   = per_q;
    to_d    = to_q;
    mv_d    = 1'b0;
    if (clr) begin
      vhi_d   = '0;
      vlo_d   = '0;
      cnt_d   = '0;
      armed_d = 1'b0;
      amp_d   = '0;
      per_d   = '0;
      to_d    = 1'b0;
    end else if (s_valid) begin
      unique case (state_q)
        ACQ: begin
          vhi_d = sample;
          vlo_d = sample;
        end
        LOW: begin
          if (is_hi) begin
            vhi_d   = sample;
            armed_d = 1'b1;
            cnt_d   = '0;
            if (armed_q) begin
              mv_d  = 1'b1;
              amp_d = DW'(half_span(32'($signed(vhi_q)), 32'($signed(vlo_q))));
              per_d = cnt_inc;
              to_d  = 1'b0;
            end
          end else if ($signed(sample) < $signed(vlo_q)) begin
            vlo_d = sample;
          end
        end
        HIGH: begin
          if (is_lo) begin
            vlo_d = sample;
          end else if ($signed(sample) > $signed(vhi_q)) begin
            vhi_d = sample;
          end
        end
        default: ;
      endcase
      if (tick) begin
        if (cnt_full) begin
          to_d    = 1'b1;
          armed_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      vhi_q   <= '0;
      vlo_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      amp_q   <= '0;
      per_q   <= '0;
      to_q    <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      vhi_q   <= vhi_d;
      vlo_q   <= vlo_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      amp_q   <= amp_d;
      per_q   <= per_d;
      to_q    <= to_d;
      mv_q    <= mv_d;
    end
  end

  always_comb begin
    meas_valid  = mv_q;
    meas_amp    = amp_q;
    meas_period = per_q;
    timeout     = to_q;
  end

endmodule

// File: rtl/lpf_pkdet_meas.sv
// Multi-channel half peak-to-peak amplitude and period meter for sampled filter outputs.
module lpf_pkdet_meas
  import lpf_meas_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = DefDw,
  parameter int unsigned PW  = DefPw
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              s_valid,
  input  logic [NCH*DW-1:0] s_data,
  input  logic [DW-1:0]     mid,
  input  logic [DW-2:0]     hyst,
  output logic [NCH-1:0]    meas_valid,
  output logic [NCH*DW-1:0] meas_amp,
  output logic [NCH*PW-1:0] meas_period,
  output logic [NCH-1:0]    timeout
);

  // One extra bit keeps mid +/- hyst exact at the rails.
  logic signed [DW:0] th_hi, th_lo;

  assign th_hi = $signed({mid[DW-1], mid}) + $signed({2'b00, hyst});
  assign th_lo = $signed({mid[DW-1], mid}) - $signed({2'b00, hyst});

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    pkdet_chan #(
      .DW(DW),
      .PW(PW)
    ) u_chan (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .clr        (clr),
      .s_valid    (s_valid),
      .sample     (s_data[c*DW +: DW]),
      .mid        (mid),
      .th_hi      (th_hi),
      .th_lo      (th_lo),
      .meas_valid (meas_valid[c]),
      .meas_amp   (meas_amp[c*DW +: DW]),
      .meas_period(meas_period[c*PW +: PW]),
      .timeout    (timeout[c])
    );
  end

endmodule

// File: doc/lpf_pkdet_meas.md
Name: lpf_pkdet_meas

Overview:
Clocked, multi-channel successor to the behavioural filter-output peak detector. It takes sampled signed filter outputs, for example from a DMS LPF model quantised by an ADC stage. Per channel, it measures half peak-to-peak amplitude and period in samples once per full waveform cycle. It adds crossing hysteresis, period counting, timeout detection and synchronous clear. Its outputs feed trim-calibration and gain-sweep logic.

Parameters:
NCH, 4, number of independent channels
DW, 12, signed sample width (two's complement)
PW, 16, period counter width (unsigned, saturating)

Ports:
refclk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of all channel state
s_valid  input  1  sample strobe common to all channels
s_data  input  NCH*DW  channel c sample in bits [c*DW +: DW], signed
mid  input  DW  signed midline (DC level), shared by all channels
hyst  input  DW-1  unsigned hysteresis half-band
meas_valid  output  NCH  one-cycle pulse per channel when a new measurement is presented
meas_amp  output  NCH*DW  per-channel (vhi-vlo)>>>1, unsigned, held until next measurement
meas_period  output  NCH*PW  per-channel samples per cycle, held until next measurement
timeout  output  NCH  sticky per-channel no-crossing flag

Behaviour:
- Reset (rst_n=0, async) clears everything. All outputs are 0 and every channel is in ACQ with armed=0 and cnt=0.
- clr=1 has the same effect as reset, applied synchronously. clr beats s_valid in the same cycle, and that sample is discarded.
- Only cycles with s_valid=1 advance state. Idle cycles hold all state.
- Thresholds are computed in DW+1 bits with no overflow: th_hi = mid + hyst, th_lo = mid - hyst. A sample is high if it is >= th_hi and low if it is < th_lo. Anything else is in-band.
- States per channel:
  - ACQ: the first valid sample goes to HIGH if sample >= mid, else LOW. vhi and vlo are set to the sample. No output.
  - LOW: vlo tracks the minimum. A high sample is a rising crossing: go to HIGH and set vhi to that sample.
  - HIGH: vhi tracks the maximum. A low sample is a falling crossing: go to LOW and set vlo to that sample.
  - In-band samples update the extremes only and never change state.
- Measurement on a rising crossing:
  - If armed=1 (a previous rising crossing exists), the sample is the next output.
  - meas_amp = (vhi_prev - vlo) computed in DW+1 bits, then shifted right arithmetically by 1. vhi_prev is the maximum before the crossing sample and vlo is the minimum of the preceding low phase. The result always fits in DW bits.
  - meas_period = cnt + 1.
  - meas_valid pulses on the next clock after the crossing sample (latency 1), and timeout for that channel clears.
  - Every rising crossing sets armed=1 and sets cnt to 0.
- Counter: cnt increments on each valid sample when armed=1.
- Timeout: if cnt reaches 2^PW-1, timeout is set and held. The channel returns to ACQ with armed=0 and cnt=0. There is no meas_valid.
- Falling crossings produce no output.
- Channels are fully independent. Simultaneous meas_valid on several channels is legal.
- Extremes: the full-scale swing from -2^(DW-1) to 2^(DW-1)-1 gives meas_amp = 2^(DW-1)-1.

Decomposition:
- Package lpf_meas_pkg holds:
  - the channel state enum {ACQ, LOW, HIGH}
  - default DW/PW localparams
  - function half_span(hi, lo) returning the DW+1-bit difference shifted right by 1
- Sub-module pkdet_chan: one channel holding the state machine, vhi/vlo, cnt, armed and output registers. The top generates NCH instances and slices the buses.

Test Plan:
1. Square wave ±500 around mid=0, hyst=0, 8 samples per period (4 high, 4 low), 4 cycles -> from the second rising crossing, meas_valid every 8 valid samples, meas_amp=500, meas_period=8.
2. Sine with amplitude 1000, 20 samples per period, mid=0, hyst=50, s_valid every other clock -> meas_amp within 1000±3 and meas_period=20. Pulse spacing is 40 clocks, which checks that idle cycles do not count.
3. DC offset: sine with amplitude 300 around mid=400 and hyst=20, then mid=0 -> meas_amp ≈ 300 with mid=400. With mid=0 the signal never reaches a low sample, so there is no meas_valid, and timeout=1 after 2^PW-1 samples (use PW=6: 63 samples).
4. Chatter: ±5 noise around mid with hyst=10 -> no state change, no meas_valid. Then a ±200 square -> measurements resume and clear timeout.
5. clr asserted with s_valid mid-cycle -> state returns to ACQ and the next measurement appears only after two further rising crossings. Async rst_n pulsed off-edge -> all outputs 0 immediately.
6. NCH=4 with distinct periods 6/10/14/22 and full-scale channel 3 -> independent meas_period values, simultaneous pulses where they coincide, and channel 3 meas_amp=2047 (DW=12).
